// File: rtl/led_blink_pkg.sv
// Shared constants and types for the LED blink controller: GPO word field layout and the phase FSM state.
package led_blink_pkg;

  localparam int unsigned MASK_LSB = 0;
  localparam int unsigned MASK_W   = 4;
  localparam int unsigned PER_LSB  = 4;
  localparam int unsigned PER_W    = 7;
  localparam int unsigned CFG_W    = 11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } blink_state_t;

endpackage

// File: rtl/led_blink_ctrl_if.sv
// Bundle carrying the GPO config word in and the LED drive / phase / restart status out.
interface led_blink_ctrl_if
  import led_blink_pkg::*;
#(
  parameter int unsigned N_LED = 4
);

  logic [CFG_W-1:0] cfg;
  logic [N_LED-1:0] led;
  logic             phase;
  logic             restart;

  modport master (output cfg, input led, input phase, input restart);
  modport slave  (input cfg, output led, output phase, output restart);

endinterface

// File: rtl/led_tick_gen.sv
// Prescaler: emits a one-cycle tick every TICK_CYCLES enabled cycles; clr wins over en.
module led_tick_gen #(
  parameter int unsigned TICK_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // Counter sits at zero whenever disabled so each run starts a full tick period.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr || !en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/led_blink_ctrl.sv
// LED blink controller: GPO word gives LED mask and half-period; drives a square-wave blink.
// Build option: define LED_BLINK_ALT_EN to drive odd-indexed LEDs in the opposite phase.
module led_blink_ctrl
  import led_blink_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = 1_000_000,
  parameter int unsigned N_LED       = 4
) (
  input  logic             clk,
  input  logic             reset,
  led_blink_ctrl_if.slave  bus
);

  logic [CFG_W-1:0] cfg_q;
  blink_state_t     state;
  logic [PER_W-1:0] hp_cnt;
  logic             restart_q;

  logic             chg;
  logic             tick;
  logic [PER_W-1:0] per;
  logic [N_LED-1:0] mask;
  logic [N_LED-1:0] led_c;

  assign chg  = (bus.cfg != cfg_q);
  assign per  = cfg_q[PER_LSB +: PER_W];
  assign mask = cfg_q[MASK_LSB +: N_LED];

  led_tick_gen #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (chg),
    .en    (state != IDLE),
    .tick  (tick)
  );

  // Phase FSM; a config change restarts cleanly and outranks a coincident tick/expiry.
  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_q     <= '0;
      state     <= IDLE;
      hp_cnt    <= '0;
      restart_q <= 1'b0;
    end else begin
      cfg_q     <= bus.cfg;
      restart_q <= chg;
      if (chg) begin
        hp_cnt <= '0;
        state  <= (bus.cfg[MASK_LSB +: N_LED] != '0) ? ON : IDLE;
      end else if (tick) begin
        if (hp_cnt == per) begin
          hp_cnt <= '0;
          state  <= (state == ON) ? OFF : ON;
        end else begin
          hp_cnt <= hp_cnt + PER_W'(1);
        end
      end
    end
  end

`ifdef LED_BLINK_ALT_EN
  // Even LEDs light in ON, odd LEDs light in OFF.
  always_comb begin
    led_c = '0;
    for (int i = 0; i < int'(N_LED); i++) begin
      if (state == ON) begin
        led_c[i] = mask[i] & (i % 2 == 0);
      end else if (state == OFF) begin
        led_c[i] = mask[i] & (i % 2 == 1);
      end
    end
  end
`else
  always_comb begin
    led_c = '0;
    if (state == ON) begin
      led_c = mask;
    end
  end
`endif

  assign bus.led     = led_c;
  assign bus.phase   = (state == ON);
  assign bus.restart = restart_q;

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Directed self-checking bench for led_blink_ctrl with TICK_CYCLES=4, N_LED=4.
module tb_led_blink_ctrl;
  import led_blink_pkg::*;

  localparam int unsigned TICK = 4;
  localparam int unsigned NL   = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  led_blink_ctrl_if #(.N_LED(NL)) bus ();

  led_blink_ctrl #(
    .TICK_CYCLES (TICK),
    .N_LED       (NL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int passed = 0;

  // ph: 0 = idle, 1 = ON, 2 = OFF
  function automatic logic [3:0] exp_led(input logic [3:0] m, input int ph);
`ifdef LED_BLINK_ALT_EN
    if (ph == 1) return m & 4'b0101;
    if (ph == 2) return m & 4'b1010;
    return 4'b0000;
`else
    return (ph == 1) ? m : 4'b0000;
`endif
  endfunction

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    reset   = 1'b1;
    bus.cfg = '0;
    for (int c = 0; c < 10; c++) begin
      step();
      checks++;
      if ({bus.led, bus.phase, bus.restart} !== 6'b0)
        $display("FAIL reset c=%0d got led=%b phase=%b restart=%b want all 0", c, bus.led, bus.phase, bus.restart);
      else passed++;
    end
    reset = 1'b0;
    step(2);
    checks++;
    if ({bus.led, bus.phase, bus.restart} !== 6'b0)
      $display("FAIL reset_release got led=%b phase=%b restart=%b want all 0", bus.led, bus.phase, bus.restart);
    else passed++;
  endtask

  task automatic test_blink;
    logic [5:0] exp;
    int ph;
    bus.cfg = 11'h015;
    for (int c = 0; c < 24; c++) begin
      step();
      ph  = ((c / 8) % 2 == 0) ? 1 : 2;
      exp = {exp_led(4'h5, ph), ph == 1, c == 0};
      checks++;
      if ({bus.led, bus.phase, bus.restart} !== exp)
        $display("FAIL blink c=%0d got %b want %b", c, {bus.led, bus.phase, bus.restart}, exp);
      else passed++;
    end
  endtask

  task automatic test_mid_change;
    logic [5:0] exp;
    int ph;
    bus.cfg = 11'h000;
    step(2);
    bus.cfg = 11'h015;
    step(5);
    checks++;
    if (bus.led !== exp_led(4'h5, 1))
      $display("FAIL mid_pre got led=%b want %b", bus.led, exp_led(4'h5, 1));
    else passed++;
    bus.cfg = 11'h00F;
    for (int c = 0; c < 12; c++) begin
      step();
      ph  = (c < 4 || c >= 8) ? 1 : 2;
      exp = {exp_led(4'hF, ph), ph == 1, c == 0};
      checks++;
      if ({bus.led, bus.phase, bus.restart} !== exp)
        $display("FAIL mid_change c=%0d got %b want %b", c, {bus.led, bus.phase, bus.restart}, exp);
      else passed++;
    end
  endtask

  task automatic test_coincide;
    logic [5:0] exp;
    int ph;
    bus.cfg = 11'h000;
    step(2);
    bus.cfg = 11'h015;
    step(8);
    // next edge has tick and half-period expiry; the change must win
    bus.cfg = 11'h025;
    for (int c = 0; c < 13; c++) begin
      step();
      ph  = (c < 12) ? 1 : 2;
      exp = {exp_led(4'h5, ph), ph == 1, c == 0};
      checks++;
      if ({bus.led, bus.phase, bus.restart} !== exp)
        $display("FAIL coincide c=%0d got %b want %b", c, {bus.led, bus.phase, bus.restart}, exp);
      else passed++;
    end
  endtask

  task automatic test_partial_change;
    logic [5:0] exp;
    int ph;
    // mask-only change while in OFF
    bus.cfg = 11'h02A;
    step();
    exp = {exp_led(4'hA, 1), 1'b1, 1'b1};
    checks++;
    if ({bus.led, bus.phase, bus.restart} !== exp)
      $display("FAIL mask_only got %b want %b", {bus.led, bus.phase, bus.restart}, exp);
    else passed++;
    step(4);
    // period-only change
    bus.cfg = 11'h03A;
    for (int c = 0; c < 17; c++) begin
      step();
      ph  = (c < 16) ? 1 : 2;
      exp = {exp_led(4'hA, ph), ph == 1, c == 0};
      checks++;
      if ({bus.led, bus.phase, bus.restart} !== exp)
        $display("FAIL per_only c=%0d got %b want %b", c, {bus.led, bus.phase, bus.restart}, exp);
      else passed++;
    end
  endtask

  task automatic test_back_to_back;
    logic [5:0] exp;
    bus.cfg = 11'h001;
    step();
    bus.cfg = 11'h002;
    step();
    exp = {exp_led(4'h2, 1), 1'b1, 1'b1};
    checks++;
    if ({bus.led, bus.phase, bus.restart} !== exp)
      $display("FAIL b2b_second got %b want %b", {bus.led, bus.phase, bus.restart}, exp);
    else passed++;
    step();
    exp = {exp_led(4'h2, 1), 1'b1, 1'b0};
    checks++;
    if ({bus.led, bus.phase, bus.restart} !== exp)
      $display("FAIL b2b_hold got %b want %b", {bus.led, bus.phase, bus.restart}, exp);
    else passed++;
  endtask

  task automatic test_idle_and_reset;
    logic [5:0] exp;
    bus.cfg = 11'h7F0;
    step();
    checks++;
    if ({bus.led, bus.phase, bus.restart} !== 6'b000001)
      $display("FAIL mask0_entry got %b want 000001", {bus.led, bus.phase, bus.restart});
    else passed++;
    for (int c = 0; c < 20; c++) begin
      step();
      checks++;
      if ({bus.led, bus.phase, bus.restart} !== 6'b0)
        $display("FAIL mask0_idle c=%0d got %b want 000000", c, {bus.led, bus.phase, bus.restart});
      else passed++;
    end
    bus.cfg = 11'h013;
    step(3);
    exp = {exp_led(4'h3, 1), 1'b1, 1'b0};
    checks++;
    if ({bus.led, bus.phase, bus.restart} !== exp)
      $display("FAIL pre_reset got %b want %b", {bus.led, bus.phase, bus.restart}, exp);
    else passed++;
    reset = 1'b1;
    step();
    checks++;
    if ({bus.led, bus.phase, bus.restart} !== 6'b0)
      $display("FAIL mid_reset got %b want 000000", {bus.led, bus.phase, bus.restart});
    else passed++;
    reset = 1'b0;
    step();
    exp = {exp_led(4'h3, 1), 1'b1, 1'b1};
    checks++;
    if ({bus.led, bus.phase, bus.restart} !== exp)
      $display("FAIL held_cfg_restart got %b want %b", {bus.led, bus.phase, bus.restart}, exp);
    else passed++;
  endtask

  task automatic test_alt;
    logic [5:0] exp;
    int ph;
    bus.cfg = 11'h000;
    step(2);
    bus.cfg = 11'h00F;
    for (int c = 0; c < 16; c++) begin
      step();
      ph  = ((c / 4) % 2 == 0) ? 1 : 2;
      exp = {exp_led(4'hF, ph), ph == 1, c == 0};
      checks++;
      if ({bus.led, bus.phase, bus.restart} !== exp)
        $display("FAIL alt c=%0d got %b want %b", c, {bus.led, bus.phase, bus.restart}, exp);
      else passed++;
    end
  endtask

  initial begin
    reset   = 1'b1;
    bus.cfg = '0;
    test_reset();
    test_blink();
    test_mid_change();
    test_coincide();
    test_partial_change();
    test_back_to_back();
    test_idle_and_reset();
    test_alt();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
